// File: rtl/accum_cpu_pkg.sv
// Shared types and decode helpers for the accumulator CPU core.
package accum_cpu_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LDI  = 3'b000,
    OP_ADDI = 3'b001,
    OP_STA  = 3'b010,
    OP_LDA  = 3'b011,
    OP_ADD  = 3'b100,
    OP_JMP  = 3'b101,
    OP_JZ   = 3'b110,
    OP_HLT  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALT
  } state_e;

  function automatic opcode_e op_of(input logic [OPCODE_W-1:0] op_bits);
    return opcode_e'(op_bits);
  endfunction

  // The program ROM may only be rewritten while the core is not executing.
  function automatic logic prog_window(input state_e st);
    return (st == ST_IDLE) || (st == ST_HALT);
  endfunction

endpackage

// File: rtl/accum_cpu_mem.sv
// Generic storage array: one synchronous write port, two asynchronous read ports.
module accum_cpu_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b
);

  logic [WIDTH-1:0] mem_reg [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem_reg[waddr] <= wdata;
  end

  assign rdata_a = mem_reg[raddr_a];
  assign rdata_b = mem_reg[raddr_b];

endmodule

// File: rtl/accum_cpu_core.sv
// Accumulator CPU: writable program ROM, data RAM, fetch/execute FSM.
// Optional single-step input enabled by defining ACCUM_CPU_STEP_EN.
module accum_cpu_core
  import accum_cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 4,
  localparam int INSTR_W = OPCODE_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
`ifdef ACCUM_CPU_STEP_EN
  input  logic               step,
`endif
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [ADDR_W-1:0]  pc,
  output logic [DATA_W-1:0]  acc,
  output logic               zero,
  output logic               busy,
  output logic               halted
);

  state_e             state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [DATA_W-1:0]  acc_reg, acc_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic               step_mode_reg, step_mode_next;

  opcode_e            op;
  logic [DATA_W-1:0]  imm;
  logic [ADDR_W-1:0]  op_addr;
  logic [INSTR_W-1:0] rom_data;
  logic [INSTR_W-1:0] unused_rom_rdata_b;
  logic [DATA_W-1:0]  ram_data;
  logic               rom_we, ram_we;

  assign op      = op_of(instr_reg[INSTR_W-1 -: OPCODE_W]);
  assign imm     = instr_reg[DATA_W-1:0];
  assign op_addr = imm[ADDR_W-1:0];
  assign rom_we  = prog_we && prog_window(state_reg);
  assign ram_we  = (state_reg == ST_EXEC) && (op == OP_STA);

  accum_cpu_mem #(.WIDTH(INSTR_W), .ADDR_W(ADDR_W)) u_rom (
    .clk     (clk),
    .we      (rom_we),
    .waddr   (prog_addr),
    .wdata   (prog_data),
    .raddr_a (pc_reg),
    .rdata_a (rom_data),
    .raddr_b (prog_addr),
    .rdata_b (unused_rom_rdata_b)
  );

  // Port b of the data RAM serves the debug read.
  accum_cpu_mem #(.WIDTH(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (op_addr),
    .wdata   (acc_reg),
    .raddr_a (op_addr),
    .rdata_a (ram_data),
    .raddr_b (dbg_addr),
    .rdata_b (dbg_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      acc_reg       <= '0;
      instr_reg     <= '0;
      step_mode_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      acc_reg       <= acc_next;
      instr_reg     <= instr_next;
      step_mode_reg <= step_mode_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    acc_next       = acc_reg;
    instr_next     = instr_reg;
    step_mode_next = step_mode_reg;
    case (state_reg)
      ST_IDLE: begin
        if (run) begin
          state_next     = ST_FETCH;
          step_mode_next = 1'b0;
        end
`ifdef ACCUM_CPU_STEP_EN
        else if (step) begin
          state_next     = ST_FETCH;
          step_mode_next = 1'b1;
        end
`endif
      end
      ST_FETCH: begin
        instr_next = rom_data;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        pc_next = pc_reg + ADDR_W'(1);
        case (op)
          OP_LDI:  acc_next = imm;
          OP_ADDI: acc_next = acc_reg + imm;
          OP_LDA:  acc_next = ram_data;
          OP_ADD:  acc_next = acc_reg + ram_data;
          OP_JMP:  pc_next  = op_addr;
          OP_JZ:   if (acc_reg == '0) pc_next = op_addr;
          OP_HLT:  pc_next  = pc_reg;
          default: ;
        endcase
        // A stepped instruction always returns to IDLE, whatever run does.
        if (op == OP_HLT)               state_next = ST_HALT;
        else if (run && !step_mode_reg) state_next = ST_FETCH;
        else                            state_next = ST_IDLE;
        step_mode_next = 1'b0;
      end
      default: state_next = ST_HALT;
    endcase
  end

  assign pc     = pc_reg;
  assign acc    = acc_reg;
  assign zero   = (acc_reg == '0);
  assign busy   = (state_reg == ST_FETCH) || (state_reg == ST_EXEC);
  assign halted = (state_reg == ST_HALT);

endmodule

// File: tb/tb_accum_cpu_core.sv
// Scoreboard bench for accum_cpu_core: default instance plus a DATA_W=12/ADDR_W=3 instance.
module tb_accum_cpu_core;
  import accum_cpu_pkg::*;

  localparam int DW = 8, AW = 4, IW = 11;
  localparam int DW2 = 12, AW2 = 3, IW2 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, run, step, prog_we;
  logic [AW-1:0] prog_addr, dbg_addr, pc;
  logic [IW-1:0] prog_data;
  logic [DW-1:0] dbg_data, acc;
  logic          zero, busy, halted;

  logic           reset2, run2, step2, prog_we2;
  logic [AW2-1:0] prog_addr2, dbg_addr2, pc2;
  logic [IW2-1:0] prog_data2;
  logic [DW2-1:0] dbg_data2, acc2;
  logic           zero2, busy2, halted2;

  accum_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .run(run),
`ifdef ACCUM_CPU_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .acc(acc),
    .zero(zero), .busy(busy), .halted(halted)
  );

  accum_cpu_core #(.DATA_W(DW2), .ADDR_W(AW2)) dut2 (
    .clk(clk), .reset(reset2), .run(run2),
`ifdef ACCUM_CPU_STEP_EN
    .step(step2),
`endif
    .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2),
    .dbg_addr(dbg_addr2), .dbg_data(dbg_data2), .pc(pc2), .acc(acc2),
    .zero(zero2), .busy(busy2), .halted(halted2)
  );

  typedef enum int {K_ACC, K_PC, K_ZERO, K_BUSY, K_HALT, K_RAM, K_ACC2, K_RAM2} kind_e;
  typedef struct {
    string name;
    kind_e kind;
    int    addr;
    int    value;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  event kick;
  logic [IW-1:0] prog [16];

  // Monitor: drains the expectation queue against the DUT's observable state.
  initial begin : monitor
    exp_t e;
    int   act;
    dbg_addr  = '0;
    dbg_addr2 = '0;
    forever begin
      @(kick);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.kind == K_RAM)  dbg_addr  = AW'(e.addr);
        if (e.kind == K_RAM2) dbg_addr2 = AW2'(e.addr);
        #1;
        case (e.kind)
          K_ACC:   act = int'(acc);
          K_PC:    act = int'(pc);
          K_ZERO:  act = int'(zero);
          K_BUSY:  act = int'(busy);
          K_HALT:  act = int'(halted);
          K_RAM:   act = int'(dbg_data);
          K_ACC2:  act = int'(acc2);
          default: act = int'(dbg_data2);
        endcase
        checks++;
        if (act != e.value) begin
          errors++;
          $display("FAIL %s: got %0d, expected %0d", e.name, act, e.value);
        end else begin
          $display("ok   %s = %0d", e.name, act);
        end
      end
    end
  end

  function automatic logic [IW-1:0] enc(opcode_e op, int imm);
    logic [DW-1:0] f;
    f = imm[DW-1:0];
    return {op, f};
  endfunction

  function automatic logic [IW2-1:0] enc2(opcode_e op, int imm);
    logic [DW2-1:0] f;
    f = imm[DW2-1:0];
    return {op, f};
  endfunction

  task automatic expect_v(string name, kind_e k, int a, int v);
    exp_t e;
    e.name = name; e.kind = k; e.addr = a; e.value = v;
    exp_q.push_back(e);
  endtask

  // Hand the queued expectations to the monitor, wait for them, resync after a rising edge.
  task automatic flush();
    -> kick;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) #1;
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL flush: pending=%0d, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0; prog_we = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_prog(logic [IW-1:0] v);
    for (int i = 0; i < 16; i++) prog[i] = v;
  endtask

  task automatic load_prog(int n);
    for (int i = 0; i < n; i++) begin
      prog_we = 1'b1; prog_addr = AW'(i); prog_data = prog[i];
      @(posedge clk);
      #1;
    end
    prog_we = 1'b0;
  endtask

  task automatic run_to_halt(string name, int budget);
    run = 1'b1;
    for (int i = 0; i < budget && !halted; i++) @(posedge clk);
    #1;
    run = 1'b0;
    @(negedge clk);
    expect_v(name, K_HALT, 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b1; run = 1'b0; step = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0;
    reset2 = 1'b1; run2 = 1'b0; step2 = 1'b0; prog_we2 = 1'b0;
    prog_addr2 = '0; prog_data2 = '0;
    #12;
    do_reset();

    // Reset state
    @(negedge clk);
    expect_v("rst_pc", K_PC, 0, 0);
    expect_v("rst_acc", K_ACC, 0, 0);
    expect_v("rst_zero", K_ZERO, 0, 1);
    expect_v("rst_busy", K_BUSY, 0, 0);
    flush();
    @(negedge clk);
    expect_v("rst_halted", K_HALT, 0, 0);
    flush();

    // LDI 5; ADDI 3; STA 2; HLT
    fill_prog(enc(OP_HLT, 0));
    prog[0] = enc(OP_LDI, 5); prog[1] = enc(OP_ADDI, 3); prog[2] = enc(OP_STA, 2);
    load_prog(16);
    run_to_halt("basic_halted", 40);
    expect_v("basic_acc", K_ACC, 0, 8);
    expect_v("basic_pc", K_PC, 0, 3);
    expect_v("basic_ram2", K_RAM, 2, 8);
    flush();

    // Reset mid-run: RAM must survive
    do_reset();
    prog[0] = enc(OP_LDI, 7); prog[1] = enc(OP_STA, 5); prog[2] = enc(OP_JMP, 2);
    load_prog(3);
    run = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1; run = 1'b0;
    #3;
    reset = 1'b0;
    @(negedge clk);
    expect_v("midrst_pc", K_PC, 0, 0);
    expect_v("midrst_acc", K_ACC, 0, 0);
    expect_v("midrst_busy", K_BUSY, 0, 0);
    expect_v("midrst_ram5", K_RAM, 5, 7);
    flush();
    @(negedge clk);
    expect_v("midrst_ram2_kept", K_RAM, 2, 8);
    expect_v("midrst_halted", K_HALT, 0, 0);
    flush();

    // Overflow: 250 + 10 mod 256
    do_reset();
    fill_prog(enc(OP_HLT, 0));
    prog[0] = enc(OP_LDI, 250); prog[1] = enc(OP_ADDI, 10);
    load_prog(16);
    run_to_halt("ovf_halted", 40);
    expect_v("ovf_acc", K_ACC, 0, 4);
    expect_v("ovf_zero", K_ZERO, 0, 0);
    expect_v("ovf_pc", K_PC, 0, 2);
    flush();

    // Countdown loop exiting through JZ
    do_reset();
    fill_prog(enc(OP_HLT, 0));
    prog[0] = enc(OP_LDI, 3);    prog[1] = enc(OP_STA, 0);
    prog[2] = enc(OP_LDA, 0);    prog[3] = enc(OP_ADDI, 255);
    prog[4] = enc(OP_STA, 0);    prog[5] = enc(OP_JZ, 7);
    prog[6] = enc(OP_JMP, 2);
    load_prog(16);
    run_to_halt("loop_halted", 200);
    expect_v("loop_acc", K_ACC, 0, 0);
    expect_v("loop_zero", K_ZERO, 0, 1);
    expect_v("loop_pc", K_PC, 0, 7);
    flush();
    @(negedge clk);
    expect_v("loop_ram0", K_RAM, 0, 0);
    flush();

    // PC wrap: 16 x ADDI 1, run dropped during the 16th EXEC
    do_reset();
    fill_prog(enc(OP_ADDI, 1));
    load_prog(16);
    run = 1'b1;
    repeat (32) @(posedge clk);
    #1;
    run = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_v("wrap_acc", K_ACC, 0, 16);
    expect_v("wrap_pc", K_PC, 0, 0);
    expect_v("wrap_busy", K_BUSY, 0, 0);
    flush();

    // Drop run while in FETCH: exactly one more instruction
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_v("gate_acc", K_ACC, 0, 17);
    expect_v("gate_pc", K_PC, 0, 1);
    expect_v("gate_busy", K_BUSY, 0, 0);
    flush();

    // ROM write attempted during EXEC must be ignored
    do_reset();
    fill_prog(enc(OP_HLT, 0));
    prog[0] = enc(OP_LDI, 9);
    load_prog(16);
    run = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = AW'(1); prog_data = enc(OP_LDI, 85);
    @(posedge clk); #1;
    prog_we = 1'b0;
    run_to_halt("guard_halted", 40);
    expect_v("guard_acc", K_ACC, 0, 9);
    expect_v("guard_pc", K_PC, 0, 1);
    flush();

`ifdef ACCUM_CPU_STEP_EN
    // Three step pulses with run low
    do_reset();
    fill_prog(enc(OP_ADDI, 1));
    load_prog(16);
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      expect_v($sformatf("step%0d_busy", k), K_BUSY, 0, 0);
      expect_v($sformatf("step%0d_pc", k), K_PC, 0, k + 1);
      flush();
    end
    @(negedge clk);
    expect_v("step_acc", K_ACC, 0, 3);
    flush();
`endif

    // DATA_W=12, ADDR_W=3: 4000 + 200 mod 4096
    @(posedge clk); #1;
    reset2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prog_we2 = 1'b1; prog_addr2 = AW2'(i);
      case (i)
        0:       prog_data2 = enc2(OP_LDI, 4000);
        1:       prog_data2 = enc2(OP_ADDI, 200);
        2:       prog_data2 = enc2(OP_STA, 7);
        default: prog_data2 = enc2(OP_HLT, 0);
      endcase
      @(posedge clk); #1;
    end
    prog_we2 = 1'b0;
    run2 = 1'b1;
    for (int i = 0; i < 40 && !halted2; i++) @(posedge clk);
    #1;
    run2 = 1'b0;
    @(negedge clk);
    expect_v("p12_acc", K_ACC2, 0, 104);
    expect_v("p12_ram7", K_RAM2, 7, 104);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
